// File: rtl/codec_pkg.sv
// Shared codec constants: FSM state encoding, default frame geometry and arbitration modes.
package codec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEF_FRAME_BITS = 64;
    localparam int unsigned DEF_SAMPLE_W   = 16;

    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: combinational grant, registered last-grant for round-robin ties.
module rr_arbiter2
    import codec_pkg::*;
#(
    parameter bit RR_EN = ARB_RR
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       arb_en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = 1'b0;
        if (arb_en_i) begin
            case (req_i)
                2'b01: gnt_o = 2'b01;
                2'b10: begin
                    gnt_o    = 2'b10;
                    gnt_id_o = 1'b1;
                end
                2'b11: begin
                    // Tie: round-robin favours whoever was not granted last.
                    if (RR_EN && !last_q) begin
                        gnt_o    = 2'b10;
                        gnt_id_o = 1'b1;
                    end else begin
                        gnt_o = 2'b01;
                    end
                end
                default: gnt_o = '0;
            endcase
        end
        last_d = (|gnt_o) ? gnt_id_o : last_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Frames stereo samples from two requesters onto the codec DAC serial interface (daclrc/dacdat).
module dac_frame_scheduler
    import codec_pkg::*;
#(
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
    parameter bit          RR_EN      = ARB_RR
) (
    input  logic                  BCLK,
    input  logic                  rst_n,
    input  logic                  config_done,
    input  logic                  req0_valid,
    input  logic [2*SAMPLE_W-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [2*SAMPLE_W-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  daclrc,
    output logic                  dacdat,
    output logic                  grant_id,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int unsigned CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

    logic                  cfg_meta_q, cfg_sync_q;
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*SAMPLE_W-1:0] sh_q, sh_d;
    logic                  grant_q, grant_d;
    logic                  empty_q, empty_d;

    logic       running, arb_en, fire, data_win, gnt_id;
    logic [1:0] gnt;

    rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
        .clk_i    (BCLK),
        .rst_ni   (rst_n),
        .req_i    ({req1_valid, req0_valid}),
        .arb_en_i (arb_en),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    always_comb begin
        running  = (state_q != ST_IDLE);
        arb_en   = cfg_sync_q && ((state_q == ST_IDLE) ||
                                  (state_q == ST_RUN && cnt_q == LAST_CNT));
        fire     = |gnt;
        data_win = running && ((32'(cnt_q) < SAMPLE_W) ||
                               (32'(cnt_q) >= FRAME_BITS / 2 &&
                                32'(cnt_q) < FRAME_BITS / 2 + SAMPLE_W));

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cfg_sync_q) state_d = ST_RUN;
            // A fall on the last bit has already finished the frame, so no drain is needed.
            ST_RUN:   if (!cfg_sync_q) state_d = (cnt_q == LAST_CNT) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (cnt_q == LAST_CNT) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        cnt_d = (state_q == ST_IDLE || cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);

        sh_d    = sh_q;
        grant_d = grant_q;
        empty_d = empty_q;
        if (arb_en) begin
            sh_d    = '0;
            empty_d = !fire;
            if (fire) begin
                sh_d    = gnt[1] ? req1_data : req0_data;
                grant_d = gnt_id;
            end
        end else if (data_win) begin
            sh_d = {sh_q[2*SAMPLE_W-2:0], 1'b0};
        end

        req0_ready  = gnt[0];
        req1_ready  = gnt[1];
        daclrc      = running && (32'(cnt_q) < FRAME_BITS / 2);
        dacdat      = data_win && sh_q[2*SAMPLE_W-1];
        grant_id    = grant_q;
        frame_start = running && (cnt_q == '0);
        underrun    = running && (cnt_q == '0) && empty_q;
    end

    always_ff @(posedge BCLK or negedge rst_n) begin
        if (!rst_n) begin
            cfg_meta_q <= 1'b0;
            cfg_sync_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            grant_q    <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            cfg_meta_q <= config_done;
            cfg_sync_q <= cfg_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            grant_q    <= grant_d;
            empty_q    <= empty_d;
        end
    end

endmodule

// File: doc/dac_frame_scheduler.md
DAC_FRAME_SCHEDULER -- requirements
Module: dac_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 64, BCLK periods per stereo frame (even, >= 2*SAMPLE_W).
REQ-002 SHALL have parameter SAMPLE_W, default 16, bits per channel sample.
REQ-003 SHALL have parameter RR_EN, default 1: 1 = round-robin, 0 = fixed priority to requester 0.
REQ-004 SHALL have port BCLK  in  1  codec bit clock; every register clocked on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port config_done  in  1  codec register setup complete; asynchronous to BCLK.
REQ-007 SHALL have ports reqN_valid  in  1  requester N (N=0,1) holds a stereo sample.
REQ-008 SHALL have ports reqN_data  in  2*SAMPLE_W  sample: left in upper half, right in lower half.
REQ-009 SHALL have ports reqN_ready  out  1  sample accepted this cycle when high with reqN_valid.
REQ-010 SHALL have port daclrc  out  1  frame clock to codec: 1 = left half, 0 = right half.
REQ-011 SHALL have port dacdat  out  1  serial sample data to codec, MSB first.
REQ-012 SHALL have port grant_id  out  1  requester whose sample is in the current frame.
REQ-013 SHALL have port frame_start  out  1  one-cycle pulse on bit count 0 of every running frame.
REQ-014 SHALL have port underrun  out  1  one-cycle pulse when a frame starts with no sample accepted.

Function
REQ-015 SHALL synchronise config_done through a 2-flop synchroniser; only the synchronised value is used.
REQ-016 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN when synced config_done=1; RUN->DRAIN when it falls; DRAIN->IDLE at bit count FRAME_BITS-1.
REQ-017 SHALL keep a bit counter 0..FRAME_BITS-1, incrementing each BCLK in RUN/DRAIN, wrapping to 0, held at 0 in IDLE.
REQ-018 SHALL drive daclrc=1 for counts 0..FRAME_BITS/2-1, 0 otherwise, in RUN/DRAIN; daclrc=0 in IDLE.
REQ-019 SHALL drive dacdat with left bits at counts 0..SAMPLE_W-1, right bits at counts FRAME_BITS/2..FRAME_BITS/2+SAMPLE_W-1, 0 at all other counts and in IDLE.
REQ-020 SHALL arbitrate only in RUN at count FRAME_BITS-1 (and at the IDLE->RUN cycle); reqN_ready is combinational, high only for the granted requester in that cycle, else 0.
REQ-021 SHALL, on a fire (valid&ready), load the sample into the shift register; its MSB appears on dacdat at the next count 0 (latency 1 BCLK).
REQ-022 SHALL, with RR_EN=1, grant the lone valid requester, or when both valid the one not granted last; last-grant updates only on a fire.
REQ-023 SHALL, with RR_EN=0, grant requester 0 whenever req0_valid=1.
REQ-024 SHALL, when no requester is valid at arbitration, load all zeros, keep grant_id unchanged, and pulse underrun at the following count 0.
REQ-025 SHALL make no grant in DRAIN; the in-flight frame completes with its loaded sample, then outputs go idle.
REQ-026 SHALL require requesters to hold valid and data stable until fire; withdrawal is unsupported.

Reset
REQ-027 SHALL on rst_n=0 force state IDLE, counter 0, shift register 0, last-grant = 1 (req0 wins first tie), and all outputs 0.
REQ-028 SHALL on reset mid-frame abandon the frame immediately with no fire, no underrun pulse, and no partial output after release.

Structure
REQ-029 SHALL place state encoding, default FRAME_BITS/SAMPLE_W, and the RR/fixed mode constants in shared package codec_pkg.
REQ-030 SHALL implement grant selection in sub-module rr_arbiter2 (2 requesters, RR_EN parameter, combinational grant, registered last-grant).

Verification
REQ-031 Config_done rises, req0 only valid with 0xA5A5_5A5A -> req0_ready 1 cycle, then dacdat sends 0xA5A5 with daclrc=1 and 0x5A5A with daclrc=0, grant_id=0.
REQ-032 Both valid every frame, RR_EN=1 -> grants alternate 0,1,0,1 across 4 frames; RR_EN=0 -> 0,0,0,0.
REQ-033 No valid for one frame -> underrun pulses once at count 0, dacdat all 0 for that frame, grant_id unchanged.
REQ-034 config_done falls at count 10 -> current frame finishes, no ready in DRAIN, IDLE at count 63 with daclrc=0, dacdat=0.
REQ-035 rst_n asserted at count 20 mid-left-sample -> all outputs 0 immediately; after release and config_done, first grant goes to req0.
